// File: rtl/array_load_sequencer_pkg.sv
// array_load_sequencer_pkg
// Shared types and constants for the array load sequencer.
//   state_t     : sequencer FSM states
//   DEF_ADDR_W  : default register-file index width
//   DEF_DATA_W  : default element width
//   RF_DEPTH    : register-file depth
//   WDOG_W      : watchdog counter width
//   WDOG_LIMIT  : watchdog limit in WAIT cycles
package array_load_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT,
        REPORT
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int RF_DEPTH   = 32;
    localparam int WDOG_W     = 6;
    localparam int WDOG_LIMIT = 63;

endpackage

// File: rtl/array_load_watchdog.sv
// array_load_watchdog
// Down-counting watchdog for the checker wait phase. Only built when
// ARRAY_LOAD_TIMEOUT_EN is defined.
// Ports:
//   clock     in  system clock
//   reset     in  synchronous active-low reset
//   i_clr     in  reload the counter (held while not waiting)
//   i_en      in  count enable
//   o_expired out high during the WDOG_LIMIT-th enabled cycle
module array_load_watchdog
    import array_load_sequencer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;

    // Loaded with LIMIT-1 so the terminal count lands on the LIMIT-th cycle.
    always_ff @(posedge clock) begin
        if (!reset || i_clr) begin
            r_count <= WDOG_W'(WDOG_LIMIT - 1);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_en && (r_count == '0);

endmodule

// File: rtl/array_load_sequencer.sv
// array_load_sequencer
// Streams an array into consecutive register-file entries, launches the
// sort checker, waits for its done and returns a one-cycle result.
// Optional macro: ARRAY_LOAD_TIMEOUT_EN adds a WAIT-state watchdog.
// Ports:
//   clock, reset                 clock / synchronous active-low reset
//   start, base, length          host command
//   in_valid, in_data, in_ready  element stream
//   rf_wr_en/addr/data           register-file write port
//   go, chk_array, chk_length    checker launch
//   chk_done, chk_sorted         checker response
//   busy, result_*               host status and result
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting elements, one write per beat
// LAUNCH | go held high for GO_CYCLES cycles
// WAIT   | waiting for checker done (first cycle masks stale done)
// REPORT | one-cycle result strobe
module array_load_sequencer
    import array_load_sequencer_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int GO_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              go,
    output logic [ADDR_W-1:0] chk_array,
    output logic [ADDR_W-1:0] chk_length,
    input  logic              chk_done,
    input  logic              chk_sorted,
    output logic              busy,
    output logic              result_valid,
    output logic              result_sorted,
    output logic              result_error
);

    localparam int GO_W = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [GO_W-1:0]   r_go_cnt;
    logic              r_armed;
    logic              r_sorted;
    logic              r_error;
    logic [ADDR_W:0]   w_end;
    logic              w_range_err;
    logic              w_beat;
    logic              w_timeout;

    // One extra bit so base+length cannot wrap before the range compare.
    assign w_end       = {1'b0, base} + {1'b0, length};
    assign w_range_err = w_end > (ADDR_W + 1)'(RF_DEPTH);
    assign w_beat      = (r_state == LOAD) && in_valid && reset;

`ifdef ARRAY_LOAD_TIMEOUT_EN
    array_load_watchdog u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (r_state != WAIT),
        .i_en      (r_state == WAIT),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_go_cnt <= '0;
            r_armed  <= 1'b0;
            r_sorted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base   <= base;
                        r_len    <= length;
                        r_idx    <= '0;
                        r_go_cnt <= GO_W'(GO_CYCLES - 1);
                        r_sorted <= 1'b0;
                        r_error  <= w_range_err;
                    end
                end
                LOAD: begin
                    if (w_beat) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                LAUNCH: begin
                    r_armed <= 1'b0;
                    if (r_go_cnt != '0) begin
                        r_go_cnt <= r_go_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    r_armed <= 1'b1;
                    if (chk_done && r_armed) begin
                        r_sorted <= chk_sorted;
                        r_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_sorted <= 1'b0;
                        r_error  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        rf_wr_en      = 1'b0;
        go            = 1'b0;
        busy          = 1'b0;
        result_valid  = 1'b0;
        result_sorted = 1'b0;
        result_error  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_range_err) begin
                        w_next = REPORT;
                    end else if (length == '0) begin
                        w_next = LAUNCH;
                    end else begin
                        w_next = LOAD;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                rf_wr_en = w_beat;
                busy     = 1'b1;
                if (w_beat && (r_idx == (r_len - 1'b1))) begin
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                go   = 1'b1;
                busy = 1'b1;
                if (r_go_cnt == '0) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if ((chk_done && r_armed) || w_timeout) begin
                    w_next = REPORT;
                end
            end
            REPORT: begin
                busy          = 1'b1;
                result_valid  = 1'b1;
                result_sorted = r_sorted;
                result_error  = r_error;
                w_next        = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Outputs read as zero while reset is asserted; this also drops any
        // write beat presented in the reset cycle.
        if (!reset) begin
            in_ready      = 1'b0;
            rf_wr_en      = 1'b0;
            go            = 1'b0;
            busy          = 1'b0;
            result_valid  = 1'b0;
            result_sorted = 1'b0;
            result_error  = 1'b0;
        end
    end

    assign rf_wr_addr = r_base + r_idx;
    assign rf_wr_data = in_data;
    assign chk_array  = r_base;
    assign chk_length = r_len;

endmodule

// File: tb/tb_array_load_sequencer.sv
module tb_array_load_sequencer;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int GO_CYCLES = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              chk_done = 1'b0;
    logic              chk_sorted = 1'b0;
    logic              in_ready;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              go;
    logic [ADDR_W-1:0] chk_array;
    logic [ADDR_W-1:0] chk_length;
    logic              busy;
    logic              result_valid;
    logic              result_sorted;
    logic              result_error;

    int n_pass   = 0;
    int n_checks = 0;

    logic [ADDR_W+DATA_W-1:0] wr_q[$];
    logic [1:0]               res_q[$];
    logic [ADDR_W-1:0]        exp_arr = '0;
    logic [ADDR_W-1:0]        exp_len = '0;

    array_load_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .GO_CYCLES (GO_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base          (base),
        .length        (length),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .go            (go),
        .chk_array     (chk_array),
        .chk_length    (chk_length),
        .chk_done      (chk_done),
        .chk_sorted    (chk_sorted),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_sorted (result_sorted),
        .result_error  (result_error)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor: every write and result must match the next queued expectation.
    always @(negedge clock) begin : monitor
        logic [ADDR_W+DATA_W-1:0] e_wr;
        logic [1:0]               e_res;
        if (rf_wr_en) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%0d data=%0d", rf_wr_addr, rf_wr_data);
            end else begin
                e_wr = wr_q.pop_front();
                if ({rf_wr_addr, rf_wr_data} !== e_wr)
                    $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                             rf_wr_addr, rf_wr_data, e_wr[ADDR_W+DATA_W-1:DATA_W], e_wr[DATA_W-1:0]);
                else
                    n_pass++;
            end
        end
        if (result_valid) begin
            n_checks++;
            if (res_q.size() == 0) begin
                $display("FAIL unexpected_result sorted=%0b error=%0b", result_sorted, result_error);
            end else begin
                e_res = res_q.pop_front();
                if ({result_sorted, result_error} !== e_res)
                    $display("FAIL result got sorted=%0b error=%0b want sorted=%0b error=%0b",
                             result_sorted, result_error, e_res[1], e_res[0]);
                else
                    n_pass++;
            end
        end
        if (go) begin
            n_checks++;
            if ((chk_array !== exp_arr) || (chk_length !== exp_len))
                $display("FAIL chk_ptr got array=%0d len=%0d want array=%0d len=%0d",
                         chk_array, chk_length, exp_arr, exp_len);
            else
                n_pass++;
        end
    end

    function automatic bit is_sorted(input logic [DATA_W-1:0] d[$]);
        for (int i = 1; i < d.size(); i++)
            if (d[i] < d[i-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        exp_arr = b;
        exp_len = l;
        base    = b;
        length  = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [ADDR_W-1:0] b, input logic [DATA_W-1:0] d[$], input bit stall);
        for (int i = 0; i < d.size(); i++) begin
            if (stall) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = d[i];
            wr_q.push_back({ADDR_W'(b + ADDR_W'(i)), d[i]});
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Checker model: waits for go, counts its width, answers with done after the
    // mask cycle. With stale=1 an opposite-valued done is already high in the first WAIT cycle.
    task automatic respond(input bit sorted_val, input bit stale);
        int n;
        int gc;
        n = 0;
        while (!go && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (go !== 1'b1) $display("FAIL go_timeout go=%0b want 1", go);
        else n_pass++;
        gc = 0;
        while (go && gc < 10) begin
            gc++;
            tick();
        end
        n_checks++;
        if (gc != GO_CYCLES) $display("FAIL go_width got %0d want %0d", gc, GO_CYCLES);
        else n_pass++;
        if (stale) begin
            chk_done   = 1'b1;
            chk_sorted = ~sorted_val;
            tick();
        end
        chk_done   = 1'b1;
        chk_sorted = sorted_val;
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk_done   = 1'b0;
        chk_sorted = 1'b0;
        n_checks++;
        if (result_valid !== 1'b1) $display("FAIL result_timeout result_valid=%0b want 1", result_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_after_report busy=%0b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, in_ready, go, result_valid, result_sorted, result_error, rf_wr_en, chk_array, chk_length} !== '0)
            $display("FAIL reset_outputs busy=%0b rdy=%0b go=%0b rv=%0b wr=%0b arr=%0d len=%0d want all 0",
                     busy, in_ready, go, result_valid, rf_wr_en, chk_array, chk_length);
        else
            n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_rate();
        logic [DATA_W-1:0] d[$];
        d = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
        res_q.push_back({is_sorted(d), 1'b0});
        do_start(5'd11, 5'd5);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL load_ready in_ready=%0b want 1", in_ready);
        else n_pass++;
        feed(5'd11, d, 1'b0);
        n_checks++;
        if (go !== 1'b1) $display("FAIL go_after_last_beat go=%0b want 1", go);
        else n_pass++;
        respond(is_sorted(d), 1'b1);
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] d[$];
        d = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd5};
        res_q.push_back({is_sorted(d), 1'b0});
        do_start(5'd2, 5'd5);
        feed(5'd2, d, 1'b1);
        respond(is_sorted(d), 1'b0);
    endtask

    task automatic test_range_error();
        res_q.push_back(2'b01);
        do_start(5'd30, 5'd5);
        n_checks++;
        if ({result_valid, result_error, go} !== 3'b110)
            $display("FAIL range_err rv=%0b err=%0b go=%0b want 1 1 0", result_valid, result_error, go);
        else
            n_pass++;
        // start presented during REPORT must be ignored
        base   = 5'd0;
        length = 5'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n_checks++;
        if ({busy, go, in_ready} !== 3'b000)
            $display("FAIL start_in_report busy=%0b go=%0b rdy=%0b want 0 0 0", busy, go, in_ready);
        else
            n_pass++;
        tick();
    endtask

    task automatic test_zero_length();
        res_q.push_back(2'b10);
        do_start(5'd7, 5'd0);
        n_checks++;
        if ({go, in_ready} !== 2'b10) $display("FAIL zero_len_launch go=%0b rdy=%0b want 1 0", go, in_ready);
        else n_pass++;
        respond(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        logic [DATA_W-1:0] d[$];
        d = '{32'd40, 32'd41};
        do_start(5'd4, 5'd6);
        feed(5'd4, d, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd99;
        tick();
        n_checks++;
        if ({busy, in_ready, go, result_valid, rf_wr_en, chk_array, chk_length} !== '0)
            $display("FAIL reset_mid_load busy=%0b rdy=%0b go=%0b rv=%0b wr=%0b arr=%0d len=%0d want all 0",
                     busy, in_ready, go, result_valid, rf_wr_en, chk_array, chk_length);
        else
            n_pass++;
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        d = '{32'd3, 32'd3, 32'd8};
        res_q.push_back({is_sorted(d), 1'b0});
        do_start(5'd29, 5'd3);
        feed(5'd29, d, 1'b0);
        respond(is_sorted(d), 1'b0);
    endtask

    task automatic test_no_done();
        logic [DATA_W-1:0] d[$];
        int n;
        d = '{32'd5};
        do_start(5'd1, 5'd1);
        feed(5'd1, d, 1'b0);
        n = 0;
        while (go && n < 10) begin
            tick();
            n++;
        end
`ifdef ARRAY_LOAD_TIMEOUT_EN
        res_q.push_back(2'b01);
        n = 1;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 64) $display("FAIL timeout_cycle got %0d want 64", n);
        else n_pass++;
        tick();
`else
        repeat (100) tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL wait_forever busy=%0b want 1", busy);
        else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_range_error();
        test_zero_length();
        test_reset_mid_load();
        test_no_done();
        repeat (3) tick();
        n_checks++;
        if ((wr_q.size() != 0) || (res_q.size() != 0))
            $display("FAIL leftover writes=%0d results=%0d want 0 0", wr_q.size(), res_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/array_load_sequencer.md
# array_load_sequencer

Upstream feeder for the array sort checker. Accepts a start command (base register, length), streams `length` 32-bit elements over a valid/ready input into consecutive register-file entries starting at `base`, and then launches the checker by driving its `go`, array pointer and length. Waits for the checker's `done` and returns a single-cycle result (`sorted` or `error`) to the host. Sits between the host/test stimulus and the sort-check datapath/control pair, and owns the register-file write port during a run.

## Interface
Parameters:
- ADDR_W, 5, register-file index width; also the width of `base` and `length`.
- DATA_W, 32, element width.
- GO_CYCLES, 2, number of cycles `go` is held high during launch.

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-low; sampled on the `clock` rising edge.
- start  in  1  command strobe; accepted only in IDLE.
- base  in  ADDR_W  first register index of the array.
- length  in  ADDR_W  element count, 0..31.
- in_valid  in  1  element valid.
- in_data  in  DATA_W  element value.
- in_ready  out  1  high only in LOAD.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  ADDR_W  write index.
- rf_wr_data  out  DATA_W  write data; equals `in_data`.
- go  out  1  checker start.
- chk_array  out  ADDR_W  latched base, presented to the checker.
- chk_length  out  ADDR_W  latched length, presented to the checker.
- chk_done  in  1  checker done.
- chk_sorted  in  1  checker sorted flag; valid while `chk_done` is high.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle result strobe.
- result_sorted  out  1  registered copy of `chk_sorted`; valid with `result_valid`.
- result_error  out  1  range error or timeout; valid with `result_valid`.

## Operation
- States: IDLE, LOAD, LAUNCH, WAIT, REPORT.
- IDLE:
  - On `start`, latch `base` and `length`, and clear the index counter.
  - If `base + length > 32` (computed at 6 bits, no wrap), go to REPORT with `result_error=1`.
  - Otherwise, if `length==0`, go to LAUNCH.
  - Otherwise, go to LOAD.
  - `start` in any other state is ignored.
- LOAD:
  - `in_ready=1`. A beat completes when `in_valid && in_ready`.
  - On a beat: `rf_wr_en=1` combinationally, `rf_wr_addr = base + idx`, `rf_wr_data = in_data`, and `idx` increments.
  - After the beat with `idx == length-1`, go to LAUNCH.
  - Stalls with `in_valid=0` are unbounded.
- LAUNCH:
  - `go=1` for exactly GO_CYCLES cycles.
  - `chk_array` and `chk_length` are stable for the whole run from the cycle after `start` until REPORT exits.
  - Then go to WAIT.
- WAIT:
  - `go=0`. Go to REPORT on the first cycle with `chk_done=1` that occurs at least one cycle after `go` falls. A stale `done` left over from a previous run is therefore masked for that cycle.
  - Latch `chk_sorted` into `result_sorted`.
- REPORT:
  - `result_valid=1` for one cycle, then go to IDLE.
  - `result_error=0` on normal completion.
- Zero-length arrays pass through to the checker unchanged; the checker defines the result for them (sorted).
- No writes occur outside LOAD. `rf_wr_addr` never exceeds 31.

## Timing
- Reset values: all outputs 0, state IDLE, `chk_array=0`, `chk_length=0`. Reset mid-run aborts immediately with no result strobe. A write beat in the reset cycle is not performed.
- `start` to first possible write: 1 cycle (LOAD is entered on the edge after `start`).
- Full-throughput load: `length` cycles. Then GO_CYCLES cycles in LAUNCH, then at least 1 cycle in WAIT, then REPORT.
- Range error: `result_valid` occurs 1 cycle after `start`, with no writes and no `go`.
- `start` during REPORT is ignored. A new command can be accepted the cycle after REPORT.
- `in_data` is combinationally forwarded to `rf_wr_data`. The checker sees all writes before `go` rises.

## Configuration
- ARRAY_LOAD_TIMEOUT_EN: when defined, a 6-bit watchdog runs in WAIT.
  - After 63 cycles without `chk_done`, go to REPORT with `result_error=1` and `result_sorted=0`.
  - The watchdog clears on entry to WAIT.
- Without the macro, WAIT waits indefinitely. `result_error` then only reports range errors.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, LAUNCH, WAIT, REPORT);
  - the ADDR_W and DATA_W defaults;
  - the register-file depth constant (32);
  - the watchdog limit (63).
- One sub-module, `array_load_watchdog`: a counter with clear/enable and an expired output, instantiated only under ARRAY_LOAD_TIMEOUT_EN. Everything else stays in one FSM plus datapath module.

## Test plan
- base=11, length=5, stream 11..15 with no stalls -> writes to r11..r15 on 5 consecutive cycles, `go` high for 2 cycles with chk_array=11 and chk_length=5, then result_valid=1 and result_sorted=1.
- base=2, stream 1,2,3,2,5 with in_valid toggling every other cycle -> 5 writes at r2..r6 only on beats, result_sorted=0.
- base=30, length=5 -> result_valid 1 cycle after `start`, result_error=1, no rf_wr_en, no `go`.
- length=0, base=7 -> no writes, `go` pulses, result_sorted=1.
- Reset asserted low during LOAD after 2 beats -> outputs 0 next cycle, no result strobe. A fresh `start` afterwards runs normally.
- With ARRAY_LOAD_TIMEOUT_EN and chk_done tied 0 -> result_error=1 on cycle 64 after entering WAIT. Without the macro -> busy stays 1.
